// File: rtl/matrix_load_if.sv
// Parser and storage-bank signals seen by the matrix load controller.
// master = controller side, slave = parser/storage side.
interface matrix_load_if #(
    parameter int SLOT_W = 3
);
    logic              parser_start;
    logic              parser_busy;
    logic              parse_error;
    logic              data_valid;
    logic [2:0]        p_rows;
    logic [2:0]        p_cols;
    logic [99:0]       p_matrix;
    logic              st_we;
    logic [SLOT_W-1:0] st_addr;
    logic [2:0]        st_rows;
    logic [2:0]        st_cols;
    logic [99:0]       st_data;

    modport master (
        output parser_start, st_we, st_addr, st_rows, st_cols, st_data,
        input  parser_busy, parse_error, data_valid, p_rows, p_cols, p_matrix
    );

    modport slave (
        input  parser_start, st_we, st_addr, st_rows, st_cols, st_data,
        output parser_busy, parse_error, data_valid, p_rows, p_cols, p_matrix
    );
endinterface

// File: rtl/matrix_load_ctrl.sv
// Matrix load controller: runs the UART parser once per operand,
// writes results to storage, retries on error/timeout, checks dims.
module matrix_load_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3,
    parameter int SLOT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [1:0]        load_mode,
    input  logic [SLOT_W-1:0] slot_base,
    input  logic              abort,
    matrix_load_if.master     bus,
    output logic              ctrl_busy,
    output logic              load_done,
    output logic              load_fail,
    output logic [1:0]        fail_code,
    output logic [1:0]        retry_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT, S_RELEASE, S_DONE, S_FAIL
    } state_t;

    localparam int                TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]        MAX_R  = 2'(MAX_RETRY);
    localparam logic [SLOT_W-1:0] ONE    = SLOT_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [SLOT_W-1:0] base_q, base_d;
    logic              idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        a_rows_q, a_rows_d;
    logic [2:0]        a_cols_q, a_cols_d;
    logic              rel_q, rel_d;
    logic              retry_q, retry_d;
    logic              parser_start_q, parser_start_d;
    logic              st_we_q, st_we_d;
    logic [SLOT_W-1:0] st_addr_q, st_addr_d;
    logic [2:0]        st_rows_q, st_rows_d;
    logic [2:0]        st_cols_q, st_cols_d;
    logic [99:0]       st_data_q, st_data_d;
    logic              load_done_q, load_done_d;
    logic              load_fail_q, load_fail_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [1:0]        retry_cnt_q, retry_cnt_d;

    logic       go_fail;
    logic [1:0] fcode;
    logic       dims_ok;
    logic       timeout;

    assign dims_ok = (mode_q == 2'b01)
                   ? (bus.p_rows == a_rows_q && bus.p_cols == a_cols_q)
                   : (a_cols_q == bus.p_rows);
    assign timeout = (timer_q == T_LAST);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        base_d         = base_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        a_rows_d       = a_rows_q;
        a_cols_d       = a_cols_q;
        rel_d          = rel_q;
        retry_d        = retry_q;
        parser_start_d = parser_start_q;
        st_we_d        = 1'b0;
        st_addr_d      = st_addr_q;
        st_rows_d      = st_rows_q;
        st_cols_d      = st_cols_q;
        st_data_d      = st_data_q;
        load_done_d    = 1'b0;
        load_fail_d    = 1'b0;
        fail_code_d    = fail_code_q;
        retry_cnt_d    = retry_cnt_q;
        go_fail        = 1'b0;
        fcode          = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    fail_code_d = 2'b00;
                    retry_cnt_d = 2'b00;
                    if (load_mode == 2'b11) begin
                        go_fail = 1'b1;
                    end else begin
                        mode_d  = load_mode;
                        base_d  = slot_base;
                        idx_d   = 1'b0;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (abort) begin
                    go_fail = 1'b1;
                end else begin
                    parser_start_d = 1'b1;
                    timer_d        = '0;
                    state_d        = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_d = timeout ? timer_q : timer_q + 1'b1;
                if (abort) begin
                    go_fail = 1'b1;
                end else if (bus.data_valid) begin
                    if (idx_q && !dims_ok) begin
                        go_fail = 1'b1;
                        fcode   = 2'b11;
                    end else begin
                        st_we_d        = 1'b1;
                        st_addr_d      = idx_q ? base_q + ONE : base_q;
                        st_rows_d      = bus.p_rows;
                        st_cols_d      = bus.p_cols;
                        st_data_d      = bus.p_matrix;
                        a_rows_d       = idx_q ? a_rows_q : bus.p_rows;
                        a_cols_d       = idx_q ? a_cols_q : bus.p_cols;
                        retry_d        = 1'b0;
                        rel_d          = 1'b0;
                        parser_start_d = 1'b0;
                        state_d        = S_RELEASE;
                    end
                end else if (bus.parse_error || timeout) begin
                    if (retry_cnt_q < MAX_R) begin
                        retry_cnt_d    = retry_cnt_q + 1'b1;
                        retry_d        = 1'b1;
                        rel_d          = 1'b0;
                        parser_start_d = 1'b0;
                        state_d        = S_RELEASE;
                    end else begin
                        go_fail = 1'b1;
                        fcode   = bus.parse_error ? 2'b01 : 2'b10;
                    end
                end
            end
            S_RELEASE: begin
                parser_start_d = 1'b0;
                if (abort) begin
                    go_fail = 1'b1;
                end else if (!rel_q) begin
                    rel_d = 1'b1;
                end else if (!bus.parser_busy) begin
                    if (retry_q) begin
                        retry_d = 1'b0;
                        state_d = S_START;
                    end else if (!idx_q && mode_q != 2'b00) begin
                        idx_d       = 1'b1;
                        retry_cnt_d = 2'b00;
                        state_d     = S_START;
                    end else begin
                        load_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAIL: begin
                parser_start_d = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every failure path lands here so the pulse and code stay aligned.
        if (go_fail) begin
            state_d        = S_FAIL;
            fail_code_d    = fcode;
            load_fail_d    = 1'b1;
            parser_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mode_q         <= 2'b00;
            base_q         <= '0;
            idx_q          <= 1'b0;
            timer_q        <= '0;
            a_rows_q       <= 3'd0;
            a_cols_q       <= 3'd0;
            rel_q          <= 1'b0;
            retry_q        <= 1'b0;
            parser_start_q <= 1'b0;
            st_we_q        <= 1'b0;
            st_addr_q      <= '0;
            st_rows_q      <= 3'd0;
            st_cols_q      <= 3'd0;
            st_data_q      <= '0;
            load_done_q    <= 1'b0;
            load_fail_q    <= 1'b0;
            fail_code_q    <= 2'b00;
            retry_cnt_q    <= 2'b00;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            base_q         <= base_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            a_rows_q       <= a_rows_d;
            a_cols_q       <= a_cols_d;
            rel_q          <= rel_d;
            retry_q        <= retry_d;
            parser_start_q <= parser_start_d;
            st_we_q        <= st_we_d;
            st_addr_q      <= st_addr_d;
            st_rows_q      <= st_rows_d;
            st_cols_q      <= st_cols_d;
            st_data_q      <= st_data_d;
            load_done_q    <= load_done_d;
            load_fail_q    <= load_fail_d;
            fail_code_q    <= fail_code_d;
            retry_cnt_q    <= retry_cnt_d;
        end
    end

    assign bus.parser_start = parser_start_q;
    assign bus.st_we        = st_we_q;
    assign bus.st_addr      = st_addr_q;
    assign bus.st_rows      = st_rows_q;
    assign bus.st_cols      = st_cols_q;
    assign bus.st_data      = st_data_q;
    assign ctrl_busy        = (state_q != S_IDLE);
    assign load_done        = load_done_q;
    assign load_fail        = load_fail_q;
    assign fail_code        = fail_code_q;
    assign retry_cnt        = retry_cnt_q;
endmodule

// File: tb/tb_matrix_load_ctrl.sv
// Bench for matrix_load_ctrl: behavioural parser plus write/outcome
// scoreboards filled when each load is launched.
module tb_matrix_load_ctrl;
    typedef struct {
        int          kind;
        int          delay;
        logic [2:0]  r;
        logic [2:0]  c;
        logic [99:0] m;
    } resp_t;

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  r;
        logic [2:0]  c;
        logic [99:0] d;
    } wr_t;

    typedef struct {
        logic       ok;
        logic [1:0] code;
        logic [1:0] rc;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic [1:0] load_mode;
    logic [2:0] slot_base;
    logic       abort;
    logic       ctrl_busy;
    logic       load_done;
    logic       load_fail;
    logic [1:0] fail_code;
    logic [1:0] retry_cnt;

    matrix_load_if #(.SLOT_W(3)) bus ();

    matrix_load_ctrl #(
        .TIMEOUT_CYCLES(64),
        .MAX_RETRY     (3),
        .SLOT_W        (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .load_mode(load_mode),
        .slot_base(slot_base),
        .abort    (abort),
        .bus      (bus),
        .ctrl_busy(ctrl_busy),
        .load_done(load_done),
        .load_fail(load_fail),
        .fail_code(fail_code),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    resp_t rq[$];
    wr_t   expwr[$];
    out_t  outq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int attempts = 0;
    int cyc = 0;
    int dv_cyc = 0;
    int lo_len = 100;
    int hi_len = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic resp_t mk(input int kind, input int delay,
                                 input logic [2:0] r, input logic [2:0] c);
        resp_t x;
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        x.kind  = kind;
        x.delay = delay;
        x.r     = r;
        x.c     = c;
        x.m     = t[99:0];
        return x;
    endfunction

    // Parser model and output monitor share one process so cycle stamps agree.
    initial begin : model
        logic  prev, st, prev_we;
        int    cnt, dv_left, tail;
        bit    active;
        resp_t cur;
        wr_t   w;
        out_t  o;
        prev = 1'b0; prev_we = 1'b0; cnt = 0; dv_left = 0; tail = 0;
        active = 1'b0;
        cur = mk(3, 1, 3'd1, 3'd1);
        bus.parser_busy = 1'b0;
        bus.parse_error = 1'b0;
        bus.data_valid  = 1'b0;
        bus.p_rows      = 3'd0;
        bus.p_cols      = 3'd0;
        bus.p_matrix    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                bus.parser_busy = 1'b0;
                bus.parse_error = 1'b0;
                bus.data_valid  = 1'b0;
                active = 1'b0; prev = 1'b0; prev_we = 1'b0;
                lo_len = 100; hi_len = 0;
                cur.kind = 3;
                continue;
            end
            st = bus.parser_start;
            if (bus.data_valid) begin
                dv_left--;
                if (dv_left <= 0) bus.data_valid = 1'b0;
            end
            if (st && !prev) begin
                if (attempts > 0) check("gap", lo_len >= 2, 1);
                lo_len = 0;
                attempts++;
                cur = (rq.size() != 0) ? rq.pop_front() : mk(3, 1, 3'd1, 3'd1);
                cnt = cur.delay;
                active = 1'b1;
                bus.parser_busy = 1'b1;
            end else if (st && active) begin
                cnt--;
                if (cnt <= 0) begin
                    active = 1'b0;
                    if (cur.kind == 0) begin
                        bus.p_rows     = cur.r;
                        bus.p_cols     = cur.c;
                        bus.p_matrix   = cur.m;
                        bus.data_valid = 1'b1;
                        dv_left = 5;
                        dv_cyc  = cyc;
                    end else if (cur.kind == 1) begin
                        bus.parse_error = 1'b1;
                    end
                end
            end
            if (!st && prev) begin
                if (cur.kind == 2) check("to_len", hi_len, 64);
                hi_len = 0;
                bus.parse_error = 1'b0;
                active = 1'b0;
                tail = 2;
            end else if (!st && bus.parser_busy) begin
                tail--;
                if (tail <= 0) bus.parser_busy = 1'b0;
            end
            if (st) hi_len++;
            else lo_len++;
            prev = st;

            if (bus.st_we) begin
                check("we_b2b", prev_we, 0);
                if (expwr.size() == 0) begin
                    check("wr_unexp", 1, 0);
                end else begin
                    w = expwr.pop_front();
                    check("wr_addr", bus.st_addr, w.a);
                    check("wr_rows", bus.st_rows, w.r);
                    check("wr_cols", bus.st_cols, w.c);
                    check("wr_data", bus.st_data, w.d);
                    check("wr_lat", cyc - dv_cyc, 1);
                end
            end
            prev_we = bus.st_we;
            if (load_done || load_fail) begin
                if (outq.size() == 0) begin
                    check("out_unexp", 1, 0);
                end else begin
                    o = outq.pop_front();
                    check("out_done", load_done, o.ok);
                    check("out_fail", load_fail, !o.ok);
                    if (!o.ok) check("fail_code", fail_code, o.code);
                    check("retry_cnt", retry_cnt, o.rc);
                    if (o.ok) begin
                        check("rel_len", lo_len >= 2, 1);
                        check("busy_done", bus.parser_busy, 0);
                    end
                end
            end
        end
    end

    task automatic wait_out(input int budget);
        int n = 0;
        while (outq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (outq.size() != 0) begin
            check("wait_out", outq.size(), 0);
            outq.delete();
        end
    endtask

    task automatic do_load(input logic [1:0] mode, input logic [2:0] base,
                           input int budget);
        load_mode = mode;
        slot_base = base;
        load_req  = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        wait_out(budget);
        repeat (3) @(negedge clk);
        check("wr_left", expwr.size(), 0);
        expwr.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        resp_t a, b;
        int a0, n;
        rst = 1'b1; load_req = 1'b0; load_mode = 2'b00;
        slot_base = 3'd0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {bus.parser_start, bus.st_we, ctrl_busy, load_done,
                          load_fail, fail_code, retry_cnt}, 0);
        check("rst_st", {bus.st_addr, bus.st_rows, bus.st_cols}, 0);
        check("rst_data", bus.st_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single load into slot 2
        a = mk(0, 10, 3'd2, 3'd3);
        rq.push_back(a);
        expwr.push_back('{3'd2, a.r, a.c, a.m});
        outq.push_back('{1'b1, 2'd0, 2'd0});
        do_load(2'b00, 3'd2, 300);

        // mul pair wrapping from slot 7 to slot 0
        a = mk(0, 6, 3'd2, 3'd3);
        b = mk(0, 8, 3'd3, 3'd4);
        rq.push_back(a); rq.push_back(b);
        expwr.push_back('{3'd7, a.r, a.c, a.m});
        expwr.push_back('{3'd0, b.r, b.c, b.m});
        outq.push_back('{1'b1, 2'd0, 2'd0});
        do_load(2'b10, 3'd7, 300);

        // mul pair with inner-dimension mismatch
        a = mk(0, 5, 3'd2, 3'd3);
        b = mk(0, 5, 3'd2, 3'd4);
        rq.push_back(a); rq.push_back(b);
        expwr.push_back('{3'd7, a.r, a.c, a.m});
        outq.push_back('{1'b0, 2'd3, 2'd0});
        do_load(2'b10, 3'd7, 300);
        check("fc_hold", fail_code, 3);

        // two parse errors then success
        rq.push_back(mk(1, 4, 3'd1, 3'd1));
        rq.push_back(mk(1, 6, 3'd1, 3'd1));
        a = mk(0, 5, 3'd2, 3'd2);
        rq.push_back(a);
        expwr.push_back('{3'd1, a.r, a.c, a.m});
        outq.push_back('{1'b1, 2'd0, 2'd2});
        do_load(2'b00, 3'd1, 400);

        // silent parser: four timed-out attempts
        for (int i = 0; i < 4; i++) rq.push_back(mk(2, 1, 3'd1, 3'd1));
        outq.push_back('{1'b0, 2'd2, 2'd3});
        a0 = attempts;
        do_load(2'b00, 3'd3, 800);
        check("to_tries", attempts - a0, 4);

        // reserved mode fails at once without starting the parser
        outq.push_back('{1'b0, 2'd0, 2'd0});
        a0 = attempts;
        do_load(2'b11, 3'd0, 20);
        check("rsv_tries", attempts - a0, 0);

        // abort while waiting on the second operand of an add pair
        a = mk(0, 3, 3'd3, 3'd3);
        rq.push_back(a);
        rq.push_back(mk(3, 1, 3'd1, 3'd1));
        expwr.push_back('{3'd4, a.r, a.c, a.m});
        outq.push_back('{1'b0, 2'd0, 2'd0});
        a0 = attempts;
        load_mode = 2'b01; slot_base = 3'd4; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        n = 0;
        while (attempts < a0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ab_reach", attempts - a0, 2);
        repeat (3) @(negedge clk);
        load_mode = 2'b00; slot_base = 3'd6; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_ps", bus.parser_start, 0);
        wait_out(50);
        repeat (10) @(negedge clk);
        check("ab_idle", {ctrl_busy, bus.parser_start}, 0);
        check("ab_tries", attempts - a0, 2);
        check("ab_wr_left", expwr.size(), 0);
        expwr.delete();

        // reset in the middle of WAIT
        rq.push_back(mk(3, 1, 3'd1, 3'd1));
        a0 = attempts;
        load_mode = 2'b00; slot_base = 3'd5; load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        n = 0;
        while (attempts == a0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_ctl", {bus.parser_start, bus.st_we, ctrl_busy, load_done,
                           load_fail, fail_code, retry_cnt}, 0);
        check("mrst_st", {bus.st_addr, bus.st_rows, bus.st_cols}, 0);
        check("mrst_data", bus.st_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        a = mk(0, 7, 3'd4, 3'd5);
        rq.push_back(a);
        expwr.push_back('{3'd5, a.r, a.c, a.m});
        outq.push_back('{1'b1, 2'd0, 2'd0});
        do_load(2'b00, 3'd5, 300);

        repeat (5) @(negedge clk);
        check("sb_out", outq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_load_ctrl.md
Name: matrix_load_ctrl

Overview:
- Sequences the UART matrix parser to load one or two operand matrices into the matrix storage bank ahead of a calculation.
- Drives the parser's level-sensitive start and captures exactly one result per parse.
- Writes the result to a storage slot, retries on parse error or timeout, and checks operand dimensions against the requested operation.
- Sits between the top-level menu FSM and the parser/storage pair.

Parameters:
- TIMEOUT_CYCLES, 1000000: max cycles in WAIT with no result before the attempt is abandoned.
- MAX_RETRY, 3: retries allowed per matrix after the first attempt.
- SLOT_W, 3: storage slot address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  one-cycle request; sampled only in IDLE
- load_mode  in  2  00 single; 01 pair, equal dims (add/sub); 10 pair, A.cols==B.rows (mul); 11 reserved
- slot_base  in  SLOT_W  slot for matrix A; B goes to slot_base+1 (mod 2^SLOT_W)
- abort  in  1  cancel the load in progress
- parser_start  out  1  level start to parser
- parser_busy  in  1  parser busy
- parse_error  in  1  parser error flag (level)
- data_valid  in  1  parser result valid
- p_rows  in  3  parsed rows, 1-5
- p_cols  in  3  parsed cols, 1-5
- p_matrix  in  100  parsed elements; element (i,j) at [4*(5i+j)+:4]
- st_we  out  1  storage write strobe
- st_addr  out  SLOT_W  storage slot
- st_rows  out  3  rows written
- st_cols  out  3  cols written
- st_data  out  100  matrix written
- ctrl_busy  out  1  high outside IDLE
- load_done  out  1  one-cycle success pulse
- load_fail  out  1  one-cycle failure pulse
- fail_code  out  2  00 abort/reserved mode, 01 parse error, 10 timeout, 11 dim mismatch; held until next load_req
- retry_cnt  out  2  retries used on the current matrix

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: parser_start, st_we, st_addr, st_rows, st_cols, st_data, ctrl_busy, load_done, load_fail, fail_code, retry_cnt. Internal index, timer and A-dims also 0.
- States: IDLE, START, WAIT, RELEASE, DONE, FAIL.
- IDLE:
  - On load_req with load_mode≠11: latch mode and slot_base, index=0, retry_cnt=0, fail_code=0, go START.
  - On load_req with load_mode=11: go FAIL with code 00.
  - load_req outside IDLE is ignored.
- START: parser_start<=1, timer<=0, go WAIT. ctrl_busy is 1 in all states except IDLE.
- WAIT: parser_start held 1, timer increments. Priority order:
  1. abort
  2. data_valid
  3. parse_error
  4. timer==TIMEOUT_CYCLES-1
- data_valid in WAIT:
  - index 0: next cycle st_we=1 for exactly one cycle, with st_addr=slot_base and st_rows/st_cols/st_data=p_*. Record A dims.
  - index 1: check dims first (mode 01: equal rows and cols; mode 10: A.cols==p_rows).
    - Pass: write to slot_base+1 as above.
    - Fail: no st_we; go FAIL, code 11, no retry.
  - Only the first data_valid per attempt is used; repeated data_valid while parser_start is still high is ignored.
  - Go RELEASE.
- parse_error or timeout in WAIT:
  - retry_cnt<MAX_RETRY: retry_cnt+1, go RELEASE, then re-enter START.
  - Otherwise go FAIL with code 01 or 10.
- RELEASE: parser_start<=0. Stay at least 2 cycles and until parser_busy==0, then:
  - retry pending: go START.
  - else, more matrices (index 0 and mode≠00): index=1, retry_cnt=0, go START.
  - else go DONE.
- DONE: load_done=1 for one cycle, go IDLE.
- FAIL: parser_start<=0, load_fail=1 for one cycle. fail_code is already valid in this cycle. Go IDLE.
- abort in any non-IDLE state: go FAIL with code 00. A write already registered for the next cycle still completes. Abort in IDLE is ignored.
- Timer saturates and clears on every START.
- st_we is never high in two consecutive cycles.
- Latency: data_valid sampled to st_we high is 1 cycle.

Test Plan:
- Single load (mode 00, slot_base=2): parser returns 2x3 after 10 cycles with data_valid held 5 cycles -> exactly one st_we, st_addr=2, rows=2, cols=3, matching data; parser_start drops; load_done 2+ cycles after parser_busy low.
- Pair mul (mode 10, slot_base=7): A 2x3, B 3x4 -> writes to slots 7 and 0 (wrap), then load_done. Repeat with B 2x4 -> one write only, load_fail with fail_code=11.
- Error retry: parse_error on attempts 1 and 2, success on 3 -> retry_cnt=2, parser_start low ≥2 cycles between attempts, one st_we, load_done.
- Timeout (TIMEOUT_CYCLES=64): parser silent -> 4 attempts of 64 cycles each, then load_fail with fail_code=10, retry_cnt=3.
- Abort during WAIT on second matrix of mode 01 -> parser_start low next cycle, load_fail with fail_code=00, no second write; load_req while busy has no effect.
- Reset asserted mid-WAIT -> all outputs 0 immediately; a new load_req after release starts cleanly.
